// File: rtl/er_irq_ctrl.sv
// Executable-region / ISR attestation controller: tracks whether pc stays inside ER,
// detours only into the authorized ISR region on accepted interrupts, and aborts on DMA.
// Optional ISR residency watchdog is enabled by defining ER_IRQ_WATCHDOG_EN.
module er_irq_ctrl #(
  parameter int unsigned ISR_MAX_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] pc,
  input  logic        dma_en,
  input  logic        irq,
  input  logic [15:0] ER_min,
  input  logic [15:0] ER_max,
  input  logic [15:0] ISR_min,
  input  logic [15:0] ISR_max,
  output logic        exec,
  output logic [2:0]  state_o,
  output logic [7:0]  irq_cnt,
  output logic        abort_p
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_ISR   = 3'd2,
    S_DONE  = 3'd3,
    S_ABORT = 3'd4
  } state_t;

  if (ISR_MAX_CYCLES < 1 || ISR_MAX_CYCLES > 65535) begin : g_bad_param
    $error("er_irq_ctrl: ISR_MAX_CYCLES out of range 1..65535");
  end

  state_t     state, state_nxt;
  logic       in_er, in_isr;
  logic       cnt_clr, cnt_inc;
  logic       wdog_expire;
  logic       exec_nxt, abort_nxt;
  logic [7:0] irq_cnt_nxt;

  assign in_er  = (pc >= ER_min)  && (pc <= ER_max);
  assign in_isr = (pc >= ISR_min) && (pc <= ISR_max);

`ifdef ER_IRQ_WATCHDOG_EN
  logic [15:0] wdog_cnt;

  // wdog_cnt holds the number of ISR cycles already completed in this visit,
  // so the current cycle is the last allowed one when wdog_cnt+1 hits the limit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                    wdog_cnt <= '0;
    else if (state != S_ISR && state_nxt == S_ISR) wdog_cnt <= '0;
    else if (state == S_ISR)                       wdog_cnt <= wdog_cnt + 16'd1;
  end

  assign wdog_expire = (state == S_ISR) &&
                       (({1'b0, wdog_cnt} + 17'd1) >= 17'(ISR_MAX_CYCLES));
`else
  assign wdog_expire = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // next-state logic; ER membership is tested before ISR membership everywhere
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ABORT: begin
        if (pc == ER_min && !dma_en) begin
          state_nxt = S_RUN;
          cnt_clr   = 1'b1;
        end
      end
      S_RUN: begin
        if (dma_en && in_er)           state_nxt = S_ABORT;
        else if (!in_er && irq && in_isr) state_nxt = S_ISR;
        else if (!in_er)               state_nxt = S_ABORT;
        else if (pc == ER_max)         state_nxt = S_DONE;
      end
      S_ISR: begin
        if (dma_en)           state_nxt = S_ABORT;
        else if (wdog_expire) state_nxt = S_ABORT;
        else if (in_er) begin
          state_nxt = S_RUN;
          cnt_inc   = 1'b1;
        end
        else if (!in_isr)     state_nxt = S_ABORT;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // output logic, computed from the upcoming state so every output is registered
  always_comb begin
    exec_nxt    = (state_nxt == S_RUN) || (state_nxt == S_ISR) || (state_nxt == S_DONE);
    abort_nxt   = (state_nxt == S_ABORT) && (state != S_ABORT);
    irq_cnt_nxt = irq_cnt;
    if (cnt_clr)                       irq_cnt_nxt = 8'd0;
    else if (cnt_inc && irq_cnt != 8'hFF) irq_cnt_nxt = irq_cnt + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exec    <= 1'b0;
      abort_p <= 1'b0;
      irq_cnt <= 8'd0;
    end else begin
      exec    <= exec_nxt;
      abort_p <= abort_nxt;
      irq_cnt <= irq_cnt_nxt;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_er_irq_ctrl.sv
// Self-checking bench for er_irq_ctrl: hand-derived expectations queued per step,
// popped and compared one cycle later. Watchdog section follows ER_IRQ_WATCHDOG_EN.
module tb_er_irq_ctrl;

  localparam logic [2:0] S_IDLE = 3'd0, S_RUN = 3'd1, S_ISR = 3'd2, S_DONE = 3'd3, S_ABORT = 3'd4;

  logic        clk, reset;
  logic [15:0] pc, ER_min, ER_max, ISR_min, ISR_max;
  logic        dma_en, irq;
  logic        exec, abort_p;
  logic [2:0]  state_o;
  logic [7:0]  irq_cnt;

  typedef struct {
    logic [2:0] st;
    logic       ex;
    logic [7:0] cnt;
    logic       ab;
  } exp_t;

  exp_t sb[$];
  int   n_chk, n_fail, step_id;

  er_irq_ctrl #(.ISR_MAX_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .pc(pc), .dma_en(dma_en), .irq(irq),
    .ER_min(ER_min), .ER_max(ER_max), .ISR_min(ISR_min), .ISR_max(ISR_max),
    .exec(exec), .state_o(state_o), .irq_cnt(irq_cnt), .abort_p(abort_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".state"},   16'(state_o), 16'(e.st));
    chk({tag, ".exec"},    16'(exec),    16'(e.ex));
    chk({tag, ".irq_cnt"}, 16'(irq_cnt), 16'(e.cnt));
    chk({tag, ".abort_p"}, 16'(abort_p), 16'(e.ab));
  endtask

  // drive one pc sample, queue what the DUT must show after the next edge
  task automatic step(input logic [15:0] p, input logic d, input logic i,
                      input logic [2:0] st, input logic ex, input logic [7:0] cnt, input logic ab);
    exp_t e, got;
    pc = p; dma_en = d; irq = i;
    e.st = st; e.ex = ex; e.cnt = cnt; e.ab = ab;
    sb.push_back(e);
    @(posedge clk); #1;
    step_id++;
    got = sb.pop_front();
    chk_all($sformatf("s%0d", step_id), got);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t zero;
    n_chk = 0; n_fail = 0; step_id = 0;
    zero.st = S_IDLE; zero.ex = 1'b0; zero.cnt = 8'd0; zero.ab = 1'b0;
    ER_min = 16'hE000; ER_max = 16'hE0FF; ISR_min = 16'hF000; ISR_max = 16'hF0FF;
    pc = 16'h0000; dma_en = 1'b0; irq = 1'b0;
    reset = 1'b0;
    #2 reset = 1'b1;
    #1 chk_all("reset", zero);
    @(negedge clk) reset = 1'b0;

    // basic run to completion
    step(16'h1234, 0, 0, S_IDLE, 0, 0, 0);
    step(16'hE000, 1, 0, S_IDLE, 0, 0, 0);
    step(16'hE000, 0, 0, S_RUN,  1, 0, 0);
    step(16'hE010, 0, 0, S_RUN,  1, 0, 0);
    step(16'hE0FF, 0, 0, S_DONE, 1, 0, 0);
    step(16'h4000, 1, 1, S_DONE, 1, 0, 0);
    step(16'hE000, 1, 0, S_DONE, 1, 0, 0);
    step(16'hE000, 0, 0, S_RUN,  1, 0, 0);

    // DMA abort and restart
    step(16'hE010, 1, 0, S_ABORT, 0, 0, 1);
    step(16'hE010, 1, 0, S_ABORT, 0, 0, 0);
    step(16'hE000, 1, 0, S_ABORT, 0, 0, 0);
    step(16'hE000, 0, 0, S_RUN,   1, 0, 0);

    // authorized ISR round trip, then leaving ER without irq
    step(16'hF000, 0, 1, S_ISR,   1, 0, 0);
    step(16'hF004, 0, 0, S_ISR,   1, 0, 0);
    step(16'hE020, 0, 0, S_RUN,   1, 1, 0);
    step(16'h4000, 0, 0, S_ABORT, 0, 1, 1);
    step(16'hE000, 0, 0, S_RUN,   1, 0, 0);
    step(16'hF000, 0, 0, S_ABORT, 0, 0, 1);

    // overlapping regions: ER membership wins
    step(16'hE000, 0, 0, S_RUN, 1, 0, 0);
    ISR_min = 16'hE080;
    step(16'hE090, 0, 1, S_RUN, 1, 0, 0);
    step(16'hF010, 0, 1, S_ISR, 1, 0, 0);
    step(16'hE090, 0, 0, S_RUN, 1, 1, 0);
    ISR_min = 16'hF000;

    // DMA during ISR, stray pc during ISR
    step(16'hF000, 0, 1, S_ISR,   1, 1, 0);
    step(16'hF001, 1, 0, S_ABORT, 0, 1, 1);
    step(16'hE000, 0, 0, S_RUN,   1, 0, 0);
    step(16'hF000, 0, 1, S_ISR,   1, 0, 0);
    step(16'h1000, 0, 0, S_ABORT, 0, 0, 1);

    // ISR residency
    step(16'hE000, 0, 0, S_RUN, 1, 0, 0);
    step(16'hF004, 0, 1, S_ISR, 1, 0, 0);
`ifdef ER_IRQ_WATCHDOG_EN
    for (int k = 0; k < 7; k++) step(16'hF004, 0, 0, S_ISR, 1, 0, 0);
    step(16'hF004, 0, 0, S_ABORT, 0, 0, 1);
    step(16'hE000, 0, 0, S_RUN, 1, 0, 0);
`else
    for (int k = 0; k < 100; k++) step(16'hF004, 0, 0, S_ISR, 1, 0, 0);
    step(16'hE000, 0, 0, S_RUN, 1, 1, 0);
`endif

    // asynchronous reset mid-ISR
    step(16'hF000, 0, 1, S_ISR, 1, 8'(irq_cnt_exp_after_wd()), 0);
    #2 reset = 1'b1;
    #1 chk_all("async_rst", zero);
    @(negedge clk) reset = 1'b0;
    step(16'hE000, 0, 0, S_RUN, 1, 0, 0);

    // saturation after 256 round trips
    for (int n = 1; n <= 256; n++) begin
      step(16'hF000, 0, 1, S_ISR, 1, 8'((n - 1) > 255 ? 255 : (n - 1)), 0);
      step(16'hE020, 0, 0, S_RUN, 1, 8'(n > 255 ? 255 : n), 0);
    end
    step(16'hE0FF, 0, 0, S_DONE, 1, 8'd255, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // count carried into the async-reset scenario differs by watchdog build
  function automatic int irq_cnt_exp_after_wd();
`ifdef ER_IRQ_WATCHDOG_EN
    return 0;
`else
    return 1;
`endif
  endfunction

endmodule
